mul_arbiter: RTL
================

# mul_arbiter

Shares one unsigned N-bit multiplier among M requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants the shared multiplier to one requester at a time, sequences the multiplier's input and output handshakes, and returns the registered 2N-bit product to the granted requester only. It sits between the compute clients and the single iterative multiplier instance.

## Interface
- N, 8, operand width; must match the multiplier's N.
- M, 4, number of requesters (2..16); IW = $clog2(M).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; the multiplier instance uses the same rst.
- req_valid  in  M  per-requester operand valid.
- req_ready  out  M  per-requester accept, one-hot or zero.
- req_a, req_b  in  M*N each  packed operands; requester i uses bits [i*N +: N].
- rsp_valid  out  M  per-requester product valid, one-hot or zero.
- rsp_ready  in  M  per-requester product accept.
- rsp_product  out  2N  registered product, shared by all requesters.
- rsp_id  out  IW  index of the current owner.
- busy  out  1  high in any state other than S_IDLE.
- m_valid  out  1  drives the multiplier valid_i.
- m_ready  in  1  from the multiplier ready_i; high when the multiplier is idle.
- m_a, m_b  out  N each  multiplier operands.
- m_product  in  2N  multiplier product.
- m_done_valid  in  1  from the multiplier valid_o.
- m_done_ready  out  1  drives the multiplier ready_o.

## Operation
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP. Any illegal encoding returns to S_IDLE on the next edge.
- **S_IDLE:** the arbiter picks a winner among req_valid.
  - req_ready[winner]=1 combinationally; all other bits are 0.
  - On the transfer, latch req_a/req_b of the winner into op_a/op_b, latch owner=winner, then go to S_ISSUE.
  - If no request is valid, stay in S_IDLE.
- **S_ISSUE:** m_valid=1. When m_valid & m_ready, go to S_WAIT.
- **S_WAIT:** m_done_ready=1.
  - On m_done_valid, capture m_product into rsp_product and go to S_RESP.
  - Asserting m_done_ready in the same cycle releases the multiplier immediately.
- **S_RESP:** rsp_valid[owner]=1. When rsp_ready[owner]=1, go to S_IDLE and update the round-robin pointer last=owner.
- m_a/m_b are driven from op_a/op_b at all times.
  - They hold constant from the S_IDLE accept until the return to S_IDLE.
  - This matters because the multiplier reads its live operand inputs during computation.
- rsp_ready of non-owners is ignored.
- req_valid changes while not in S_IDLE have no effect. Requests are never dropped: a requester holds req_valid until it sees req_ready.
- Products are unsigned, full 2N width, with no truncation or overflow.

## Timing
- Reset values:
  - FSM: S_IDLE.
  - Outputs: req_ready=0, rsp_valid=0, m_valid=0, m_done_ready=0, rsp_product=0, rsp_id=0, busy=0.
  - Internal: op_a=op_b=0, last=M-1, so requester 0 wins first.
- rst asserted in any state aborts the transaction; no response is delivered. The multiplier resets on the same edge.
- Accept at cycle t; m_valid is high at t+1.
- Latency: the product is captured the cycle m_done_valid is seen, and rsp_valid rises the following cycle.
  - Overhead over the multiplier is 3 cycles: accept, issue, capture.
  - Shortcut case (a or b in {0,1}): m_done_valid at t+2, rsp_valid at t+3.
- A requester holding rsp_ready=0 stalls the arbiter in S_RESP indefinitely. No new grants are made while it stalls.
- Throughput: one transaction at a time; the earliest next accept is the cycle after the rsp handshake.
- Simultaneous requests: exactly one grant per S_IDLE cycle.

## Configuration
- MUL_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. Search starts at index (last+1) mod M and wraps, so the winner is the first valid index found.
- MUL_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest valid index wins. The last register and pointer update are removed.

## Structure
- Package mul_arb_pkg holds:
  - state_t enum {S_IDLE, S_ISSUE, S_WAIT, S_RESP}, logic [1:0].
  - MUL_ARB_MAX_M = 16.
- One combinational sub-module, rr_pick (M, IW): inputs req[M], last[IW]; outputs grant_valid and grant_id[IW]. The fixed-priority variant is selected inside it by the macro.
- The top level holds the FSM, the op/owner/result registers, and the one-hot decode for req_ready/rsp_valid.

## Test plan
- Single request: requester 2 sends a=3, b=5 → the multiplier sees m_a=3, m_b=5; rsp_valid=4'b0100, rsp_product=15, rsp_id=2.
- Shortcut: requester 0 sends a=7, b=1 accepted at t → rsp_valid[0] rises at t+3 with product 7. Also a=0, b=200 → product 0.
- Contention, round-robin: all four requesters valid continuously with distinct operands → grants in order 0,1,2,3,0, and each product matches its own operands. Without the macro → grants 0,0,0.
- Backpressure: hold rsp_ready[1]=0 for 10 cycles → rsp_valid[1] and rsp_product stay stable, req_ready stays 0, and no m_valid is asserted.
- Operand stability: change req_a/req_b of the owner during S_WAIT (a=255, b=255 issued, then changed to 0) → product is 65025, and m_a/m_b never change.
- Mid-operation reset: assert rst for one cycle during S_WAIT → every output reaches its reset value the next cycle, no rsp_valid appears, and a following request completes correctly.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and limits for the multiplier arbiter slice.
//   state_t        arbiter FSM encoding
//   MUL_ARB_MAX_M  largest supported requester count
package mul_arb_pkg;

    localparam int unsigned MUL_ARB_MAX_M = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// rr_pick: combinational winner selection among M requesters.
// Build option: MUL_ARB_ROUND_ROBIN_EN selects round-robin starting after
// 'last'; otherwise fixed priority, lowest index wins ('last' ignored).
//   req          in   M   request vector
//   last         in   IW  previous owner (round-robin pointer)
//   grant_valid  out  1   some request is set
//   grant_id     out  IW  index of the winner
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int unsigned M  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [M-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id
);

`ifdef MUL_ARB_ROUND_ROBIN_EN
    // Scan (last+1) .. (last+M) mod M; first hit wins.
    always_comb begin
        logic [IW-1:0] idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned k = 1; k <= M; k++) begin
            idx = IW'((32'(last) + k) % M);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    // Lowest valid index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (!grant_valid && req[IW'(i)]) begin
                grant_valid = 1'b1;
                grant_id    = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one iterative N-bit multiplier among M requesters.
// Build option: MUL_ARB_ROUND_ROBIN_EN (round-robin; default fixed priority).
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester operand handshake (ready one-hot)
//   req_a, req_b             packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready      per-requester product handshake (valid one-hot)
//   rsp_product, rsp_id      registered product and owner index
//   busy                     FSM not idle
//   m_valid/m_ready          multiplier input handshake
//   m_a, m_b                 multiplier operands, stable for whole transaction
//   m_product                multiplier result
//   m_done_valid/m_done_ready multiplier output handshake
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned M  = 4,
    parameter int unsigned IW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   req_valid,
    output logic [M-1:0]   req_ready,
    input  logic [M*N-1:0] req_a,
    input  logic [M*N-1:0] req_b,
    output logic [M-1:0]   rsp_valid,
    input  logic [M-1:0]   rsp_ready,
    output logic [2*N-1:0] rsp_product,
    output logic [IW-1:0]  rsp_id,
    output logic           busy,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [N-1:0]   m_a,
    output logic [N-1:0]   m_b,
    input  logic [2*N-1:0] m_product,
    input  logic           m_done_valid,
    output logic           m_done_ready
);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick_last;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic          accept;
    logic          capture;
    logic          finish;

`ifdef MUL_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] last;

    // Round-robin pointer; reset to M-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(M - 1);
        end else if (finish) begin
            last <= owner;
        end
    end
    assign pick_last = last;
`else
    assign pick_last = IW'(M - 1);
`endif

    rr_pick #(
        .M  (M),
        .IW (IW)
    ) u_pick (
        .req         (req_valid),
        .last        (pick_last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake decode.
    always_comb begin
        state_next   = state;
        req_ready    = '0;
        rsp_valid    = '0;
        m_valid      = 1'b0;
        m_done_ready = 1'b0;
        busy         = 1'b1;
        accept       = 1'b0;
        capture      = 1'b0;
        finish       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_valid) begin
                    // Winner is valid by construction, so ready implies transfer.
                    req_ready  = M'(1) << grant_id;
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                m_done_ready = 1'b1;
                if (m_done_valid) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = M'(1) << owner;
                if (rsp_ready[owner]) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand, owner and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            owner       <= '0;
            rsp_product <= '0;
        end else begin
            if (accept) begin
                op_a  <= req_a[int'(grant_id)*N +: N];
                op_b  <= req_b[int'(grant_id)*N +: N];
                owner <= grant_id;
            end
            if (capture) begin
                rsp_product <= m_product;
            end
        end
    end

    assign m_a    = op_a;
    assign m_b    = op_b;
    assign rsp_id = owner;

endmodule
